debug_ram_loader: RTL and testbench
===================================

DEBUG_RAM_LOADER -- requirements
Module: debug_ram_loader

Interface
REQ-001 SHALL have port CPU_CLK  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port CPU_RST_N  in  1  reset, synchronous, active-low.
REQ-003 SHALL have ports Cmd_Valid in 1, Cmd_Ready out 1  command handshake.
REQ-004 SHALL have port Cmd_Op  in  2  opcode: 00 WRITE, 01 READ, 10/11 reserved.
REQ-005 SHALL have port Cmd_Tgt  in  1  target RAM: 0 instruction RAM, 1 data RAM.
REQ-006 SHALL have ports Cmd_Addr in 32 (start byte address) and Cmd_Len in 8 (word count minus one, 1..256 words).
REQ-007 SHALL have ports Wr_Valid in 1, Wr_Ready out 1, Wr_Data in 32  write-beat handshake.
REQ-008 SHALL have ports Rd_Valid out 1, Rd_Ready in 1, Rd_Data out 32  read-beat handshake.
REQ-009 SHALL have ports Inst_A2 out 32, Inst_WD2 out 32, Inst_WE2 out 4, Inst_RD2 in 32  instruction-RAM debug port.
REQ-010 SHALL have ports Data_A2 out 32, Data_WD2 out 32, Data_WE2 out 4, Data_RD2 in 32  data-RAM debug port.
REQ-011 SHALL have ports Busy out 1, Done out 1, Err out 1  status.

Function
REQ-012 SHALL implement FSM states IDLE, WR, RD_ISSUE, RD_WAIT, RD_HOLD; Busy=1 in every state except IDLE.
REQ-013 SHALL assert Cmd_Ready only in IDLE; a command is accepted on Cmd_Valid&Cmd_Ready, latching op, target, Cmd_Addr with bits [1:0] forced to 0, and Cmd_Len into a remaining-word counter.
REQ-014 SHALL, on an accepted reserved op, stay in IDLE, perform no RAM access, and pulse Done and Err for exactly one cycle in the following cycle.
REQ-015 SHALL, in WR, assert Wr_Ready; on each Wr_Valid&Wr_Ready beat, drive the selected port next cycle with A2=address, WD2=Wr_Data, WE2=4'b1111, for exactly one cycle.
REQ-016 SHALL, after each write beat, increment address by 4 and decrement the counter; the beat taken with counter=0 is last, the FSM returns to IDLE next cycle, and Done pulses coincident with the last WE2 strobe.
REQ-017 SHALL hold WE2=4'b0000 on the non-selected port always and on the selected port except during REQ-015 strobes.
REQ-018 SHALL drive both A2 outputs from one shared address register; WD2 of both ports carries the last write data.
REQ-019 SHALL, for READ, enter RD_ISSUE the cycle after accept with A2=address, then RD_WAIT, then capture the selected RD2 (1-cycle registered RAM latency) into Rd_Data at the end of RD_WAIT, and enter RD_HOLD.
REQ-020 SHALL assert Rd_Valid only in RD_HOLD and hold Rd_Data stable until Rd_Valid&Rd_Ready.
REQ-021 SHALL, on a read handshake with counter>0, increment address by 4, decrement the counter, and go to RD_ISSUE; with counter=0, go to IDLE and pulse Done in that next cycle.
REQ-022 SHALL wrap the address modulo 2^32 (0xFFFFFFFC+4 = 0x00000000) without error.
REQ-023 SHALL accept a new command in the cycle the FSM reenters IDLE, including the cycle carrying the last write strobe.
REQ-024 SHALL ignore Wr_Valid outside WR and Rd_Ready outside RD_HOLD.

Reset
REQ-025 SHALL, when CPU_RST_N=0 at a clock edge, enter IDLE and clear address, counter, Rd_Data, A2, WD2 to 0, WE2 to 4'b0000, and Rd_Valid, Done, Err, Busy to 0.
REQ-026 SHALL apply REQ-025 identically mid-transfer: no further WE2 strobe or Rd_Valid after the reset edge, and the pending command is discarded.

Verification
REQ-027 Single write: WRITE tgt=0 addr=0x00000103 len=0, data 0xDEADBEEF -> one cycle Inst_A2=0x00000100, Inst_WD2=0xDEADBEEF, Inst_WE2=1111, Done high in that cycle, Data_WE2 stays 0000.
REQ-028 Burst read with backpressure: data RAM preloaded 0x10,0x20,0x30 at 0x200..0x208, READ tgt=1 addr=0x200 len=2, Rd_Ready low 3 cycles per beat -> Rd_Data 0x10,0x20,0x30 in order, each held stable while Rd_Valid=1, Done one cycle after third handshake.
REQ-029 Wrap: WRITE addr=0xFFFFFFFC len=1 -> strobes at 0xFFFFFFFC then 0x00000000.
REQ-030 Reserved op: Cmd_Op=11 -> Done and Err pulse one cycle after accept, no WE2 strobe, Busy stays 0.
REQ-031 Reset mid-burst: WRITE len=7, CPU_RST_N=0 after beat 3 -> all outputs per REQ-025 next edge, no further strobes, Cmd_Ready=1 after release.

Source files
------------

// File: rtl/debug_ram_loader.sv
// Debug loader: streams word bursts into or out of the instruction/data RAM
// debug ports under a cmd/write-beat/read-beat handshake protocol.
// Ports: CPU_CLK/CPU_RST_N; Cmd_* command; Wr_* write beats; Rd_* read beats;
// Inst_*2 / Data_*2 RAM debug ports; Busy/Done/Err status.
module debug_ram_loader (
  input  logic        CPU_CLK,
  input  logic        CPU_RST_N,
  input  logic        Cmd_Valid,
  output logic        Cmd_Ready,
  input  logic [1:0]  Cmd_Op,
  input  logic        Cmd_Tgt,
  input  logic [31:0] Cmd_Addr,
  input  logic [7:0]  Cmd_Len,
  input  logic        Wr_Valid,
  output logic        Wr_Ready,
  input  logic [31:0] Wr_Data,
  output logic        Rd_Valid,
  input  logic        Rd_Ready,
  output logic [31:0] Rd_Data,
  output logic [31:0] Inst_A2,
  output logic [31:0] Inst_WD2,
  output logic [3:0]  Inst_WE2,
  input  logic [31:0] Inst_RD2,
  output logic [31:0] Data_A2,
  output logic [31:0] Data_WD2,
  output logic [3:0]  Data_WE2,
  input  logic [31:0] Data_RD2,
  output logic        Busy,
  output logic        Done,
  output logic        Err
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ISSUE,
    RD_WAIT,
    RD_HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] a2_q, a2_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] rd_q, rd_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        tgt_q, tgt_d;
  logic        we_q, we_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  always_ff @(posedge CPU_CLK) begin
    if (!CPU_RST_N) begin
      state_q <= IDLE;
      addr_q  <= '0;
      a2_q    <= '0;
      wd_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      tgt_q   <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      a2_q    <= a2_d;
      wd_q    <= wd_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    a2_d    = a2_q;
    wd_d    = wd_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Cmd_Valid) begin
          tgt_d  = Cmd_Tgt;
          addr_d = {Cmd_Addr[31:2], 2'b00};
          cnt_d  = Cmd_Len;
          unique case (Cmd_Op)
            2'b00: state_d = WR;
            2'b01: begin
              state_d = RD_ISSUE;
              a2_d    = {Cmd_Addr[31:2], 2'b00};
            end
            default: begin
              done_d = 1'b1;
              err_d  = 1'b1;
            end
          endcase
        end
      end
      WR: begin
        if (Wr_Valid) begin
          // A2 is a separate register so the strobe shows the beat's
          // address while addr_q already advances to the next word.
          we_d   = 1'b1;
          a2_d   = addr_q;
          wd_d   = Wr_Data;
          addr_d = addr_q + 32'd4;
          if (cnt_q == 8'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        rd_d    = tgt_q ? Data_RD2 : Inst_RD2;
        state_d = RD_HOLD;
      end
      RD_HOLD: begin
        if (Rd_Ready) begin
          if (cnt_q != 8'd0) begin
            addr_d  = addr_q + 32'd4;
            a2_d    = addr_q + 32'd4;
            cnt_d   = cnt_q - 8'd1;
            state_d = RD_ISSUE;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Cmd_Ready = (state_q == IDLE);
  assign Wr_Ready  = (state_q == WR);
  assign Rd_Valid  = (state_q == RD_HOLD);
  assign Busy      = (state_q != IDLE);
  assign Done      = done_q;
  assign Err       = err_q;
  assign Rd_Data   = rd_q;

  assign Inst_A2  = a2_q;
  assign Data_A2  = a2_q;
  assign Inst_WD2 = wd_q;
  assign Data_WD2 = wd_q;
  assign Inst_WE2 = (we_q && !tgt_q) ? 4'hF : 4'h0;
  assign Data_WE2 = (we_q && tgt_q) ? 4'hF : 4'h0;

endmodule

// File: tb/tb_debug_ram_loader.sv
// Bench for debug_ram_loader: directed steps, scoreboard queues for
// write strobes and read beats, registered RAM models on both ports.
module tb_debug_ram_loader;

  logic        CPU_CLK = 1'b0;
  logic        CPU_RST_N;
  logic        Cmd_Valid, Cmd_Ready;
  logic [1:0]  Cmd_Op;
  logic        Cmd_Tgt;
  logic [31:0] Cmd_Addr;
  logic [7:0]  Cmd_Len;
  logic        Wr_Valid, Wr_Ready;
  logic [31:0] Wr_Data;
  logic        Rd_Valid, Rd_Ready;
  logic [31:0] Rd_Data;
  logic [31:0] Inst_A2, Inst_WD2, Inst_RD2;
  logic [3:0]  Inst_WE2;
  logic [31:0] Data_A2, Data_WD2, Data_RD2;
  logic [3:0]  Data_WE2;
  logic        Busy, Done, Err;

  debug_ram_loader dut (
    .CPU_CLK(CPU_CLK), .CPU_RST_N(CPU_RST_N),
    .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready),
    .Cmd_Op(Cmd_Op), .Cmd_Tgt(Cmd_Tgt),
    .Cmd_Addr(Cmd_Addr), .Cmd_Len(Cmd_Len),
    .Wr_Valid(Wr_Valid), .Wr_Ready(Wr_Ready), .Wr_Data(Wr_Data),
    .Rd_Valid(Rd_Valid), .Rd_Ready(Rd_Ready), .Rd_Data(Rd_Data),
    .Inst_A2(Inst_A2), .Inst_WD2(Inst_WD2),
    .Inst_WE2(Inst_WE2), .Inst_RD2(Inst_RD2),
    .Data_A2(Data_A2), .Data_WD2(Data_WD2),
    .Data_WE2(Data_WE2), .Data_RD2(Data_RD2),
    .Busy(Busy), .Done(Done), .Err(Err)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  logic [31:0] imem [logic [31:0]];
  logic [31:0] dmem [logic [31:0]];

  always @(posedge CPU_CLK) begin
    Inst_RD2 <= imem.exists(Inst_A2) ? imem[Inst_A2] : 32'h0;
    Data_RD2 <= dmem.exists(Data_A2) ? dmem[Data_A2] : 32'h0;
    if (Inst_WE2 == 4'hF) imem[Inst_A2] = Inst_WD2;
    if (Data_WE2 == 4'hF) dmem[Data_A2] = Data_WD2;
  end

  typedef struct {
    logic        tgt;
    logic [31:0] a;
    logic [31:0] d;
    logic        last;
  } wexp_t;

  wexp_t       wq [$];
  logic [31:0] rdq [$];
  wexp_t       e;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge CPU_CLK) begin
    if (Inst_WE2 != 4'h0 || Data_WE2 != 4'h0) begin
      if (wq.size() == 0) begin
        chk("unexp_we", {24'h0, Inst_WE2, Data_WE2}, 32'h0);
      end else begin
        e = wq.pop_front();
        chk("inst_we", {28'h0, Inst_WE2}, e.tgt ? 32'h0 : 32'hF);
        chk("data_we", {28'h0, Data_WE2}, e.tgt ? 32'hF : 32'h0);
        chk("a2", e.tgt ? Data_A2 : Inst_A2, e.a);
        chk("wd", e.tgt ? Data_WD2 : Inst_WD2, e.d);
        chk("we_done", {31'h0, Done}, {31'h0, e.last});
      end
    end
    if (Rd_Valid) begin
      if (rdq.size() == 0) begin
        chk("unexp_rd", {31'h0, Rd_Valid}, 32'h0);
      end else begin
        chk("rd_data", Rd_Data, rdq[0]);
        if (Rd_Ready) void'(rdq.pop_front());
      end
    end
  end

  task automatic cmd(input logic [1:0] op, input logic tgt,
                     input logic [31:0] a, input logic [7:0] len,
                     output int cyc);
    logic ok;
    cyc = 0;
    Cmd_Op = op; Cmd_Tgt = tgt; Cmd_Addr = a; Cmd_Len = len;
    Cmd_Valid = 1'b1;
    do begin
      @(negedge CPU_CLK);
      ok = Cmd_Ready;
      @(posedge CPU_CLK); #1;
      cyc++;
    end while (!ok && cyc < 20);
    Cmd_Valid = 1'b0;
    chk("cmd_acc", {31'h0, ok}, 32'h1);
  endtask

  task automatic wbeat(input logic [31:0] d, input logic tgt,
                       input logic [31:0] a, input logic last);
    logic ok;
    int n;
    n = 0;
    Wr_Valid = 1'b1; Wr_Data = d;
    do begin
      @(negedge CPU_CLK);
      ok = Wr_Ready;
      if (ok) wq.push_back('{tgt, a, d, last});
      @(posedge CPU_CLK); #1;
      n++;
    end while (!ok && n < 20);
    Wr_Valid = 1'b0;
    chk("wr_acc", {31'h0, ok}, 32'h1);
  endtask

  task automatic rbeat();
    logic ok;
    int n;
    n = 0;
    do begin
      @(negedge CPU_CLK);
      ok = Rd_Valid;
      n++;
    end while (!ok && n < 20);
    chk("rd_valid", {31'h0, ok}, 32'h1);
    repeat (3) @(posedge CPU_CLK);
    #1 Rd_Ready = 1'b1;
    @(posedge CPU_CLK); #1;
    Rd_Ready = 1'b0;
  endtask

  int cyc;

  initial begin
    CPU_RST_N = 1'b0;
    Cmd_Valid = 1'b0; Cmd_Op = 2'b00; Cmd_Tgt = 1'b0;
    Cmd_Addr = '0; Cmd_Len = '0;
    Wr_Valid = 1'b0; Wr_Data = '0; Rd_Ready = 1'b0;
    repeat (3) @(posedge CPU_CLK);
    #1;
    chk("rst_busy", {31'h0, Busy}, 32'h0);
    chk("rst_done", {31'h0, Done}, 32'h0);
    chk("rst_err", {31'h0, Err}, 32'h0);
    chk("rst_rdv", {31'h0, Rd_Valid}, 32'h0);
    chk("rst_rdd", Rd_Data, 32'h0);
    chk("rst_a2", Inst_A2, 32'h0);
    chk("rst_we", {24'h0, Inst_WE2, Data_WE2}, 32'h0);
    CPU_RST_N = 1'b1;
    @(posedge CPU_CLK); #1;
    chk("idle_rdy", {31'h0, Cmd_Ready}, 32'h1);

    // single write, unaligned address gets truncated
    cmd(2'b00, 1'b0, 32'h0000_0103, 8'd0, cyc);
    chk("wr_busy", {31'h0, Busy}, 32'h1);
    wbeat(32'hDEAD_BEEF, 1'b0, 32'h0000_0100, 1'b1);
    // next command accepted in the cycle holding the last strobe
    cmd(2'b00, 1'b1, 32'h0000_0200, 8'd2, cyc);
    chk("b2b_cyc", cyc, 32'd1);
    wbeat(32'h10, 1'b1, 32'h200, 1'b0);
    wbeat(32'h20, 1'b1, 32'h204, 1'b0);
    wbeat(32'h30, 1'b1, 32'h208, 1'b1);
    repeat (2) @(posedge CPU_CLK);
    #1 chk("wr_idle", {31'h0, Busy}, 32'h0);

    // burst read with backpressure
    rdq.push_back(32'h10);
    rdq.push_back(32'h20);
    rdq.push_back(32'h30);
    cmd(2'b01, 1'b1, 32'h0000_0200, 8'd2, cyc);
    rbeat();
    rbeat();
    rbeat();
    chk("rd_done", {31'h0, Done}, 32'h1);
    chk("rd_nbusy", {31'h0, Busy}, 32'h0);
    @(posedge CPU_CLK); #1;
    chk("rd_done_off", {31'h0, Done}, 32'h0);
    chk("rdq_empty", rdq.size(), 32'd0);

    // read back instruction RAM word written earlier
    rdq.push_back(32'hDEAD_BEEF);
    cmd(2'b01, 1'b0, 32'h0000_0100, 8'd0, cyc);
    rbeat();
    chk("rd1_done", {31'h0, Done}, 32'h1);

    // address wrap
    repeat (2) @(posedge CPU_CLK);
    #1;
    cmd(2'b00, 1'b1, 32'hFFFF_FFFC, 8'd1, cyc);
    wbeat(32'hA5A5_0001, 1'b1, 32'hFFFF_FFFC, 1'b0);
    wbeat(32'hA5A5_0002, 1'b1, 32'h0000_0000, 1'b1);
    repeat (2) @(posedge CPU_CLK);
    #1;

    // reserved op
    cmd(2'b11, 1'b0, 32'h0000_0040, 8'd5, cyc);
    chk("rsv_done", {31'h0, Done}, 32'h1);
    chk("rsv_err", {31'h0, Err}, 32'h1);
    chk("rsv_busy", {31'h0, Busy}, 32'h0);
    @(posedge CPU_CLK); #1;
    chk("rsv_done_off", {31'h0, Done}, 32'h0);
    chk("rsv_err_off", {31'h0, Err}, 32'h0);
    chk("rsv_busy2", {31'h0, Busy}, 32'h0);

    // reset mid-burst; Wr_Valid kept high to show it is ignored
    cmd(2'b00, 1'b0, 32'h0000_0400, 8'd7, cyc);
    wbeat(32'h0B00_0001, 1'b0, 32'h400, 1'b0);
    wbeat(32'h0B00_0002, 1'b0, 32'h404, 1'b0);
    wbeat(32'h0B00_0003, 1'b0, 32'h408, 1'b0);
    Wr_Valid = 1'b1; Wr_Data = 32'h0BAD_0BAD;
    CPU_RST_N = 1'b0;
    @(posedge CPU_CLK); #1;
    chk("mr_busy", {31'h0, Busy}, 32'h0);
    chk("mr_done", {31'h0, Done}, 32'h0);
    chk("mr_err", {31'h0, Err}, 32'h0);
    chk("mr_rdv", {31'h0, Rd_Valid}, 32'h0);
    chk("mr_rdd", Rd_Data, 32'h0);
    chk("mr_a2", Data_A2, 32'h0);
    chk("mr_wd", Inst_WD2, 32'h0);
    chk("mr_we", {24'h0, Inst_WE2, Data_WE2}, 32'h0);
    @(posedge CPU_CLK); #1;
    CPU_RST_N = 1'b1;
    repeat (5) @(posedge CPU_CLK);
    #1;
    chk("mr_rdy", {31'h0, Cmd_Ready}, 32'h1);
    chk("mr_busy2", {31'h0, Busy}, 32'h0);
    Wr_Valid = 1'b0;
    chk("wq_empty", wq.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
